// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction memory port, execute redirect and decode handshake.
interface fetch_controller_if #(
    parameter int FETCH_WIDTH = 2
);
    logic [31:0]               imem_address;
    logic [FETCH_WIDTH*32-1:0] imem_instruction;
    logic                      redirect_valid;
    logic [31:0]               redirect_target;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_pc;
    logic [FETCH_WIDTH*32-1:0] out_instruction;
    logic [FETCH_WIDTH-1:0]    out_slot_valid;
    logic                      fetch_end;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instruction,
        output out_slot_valid,
        output fetch_end
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instruction,
        input  out_slot_valid,
        input  fetch_end
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencer: drives the instruction memory from fetch_pc and buffers
// bundles in an in-order queue presented to decode; redirects flush everything.
module fetch_controller #(
    parameter int          FETCH_WIDTH     = 2,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MEM_DEPTH       = 1024,
    parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000
) (
    input  logic               clock,
    input  logic               reset,
    fetch_controller_if.master bus
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BW    = FETCH_WIDTH * 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_END
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic             fetch_end_r;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0]            pc_mem    [QUEUE_DEPTH];
    logic [BW-1:0]          instr_mem [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0] mask_mem  [QUEUE_DEPTH];

    logic [31:0]            word_idx;
    logic                   in_range;
    logic [FETCH_WIDTH-1:0] slot_mask;
    logic [BW-1:0]          bundle;
    logic                   deq;
    logic                   can_enq;
    logic                   enq;

    always_comb begin
        word_idx  = (fetch_pc - START_BYTE_ADDR) >> 2;
        in_range  = (fetch_pc >= START_BYTE_ADDR) && (word_idx < 32'(MEM_DEPTH));
        slot_mask = '0;
        bundle    = '0;
        // Slots past the memory end are zeroed so decode never sees stale data.
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            slot_mask[i] = (word_idx + i) < 32'(MEM_DEPTH);
            if (slot_mask[i]) begin
                bundle[i*32 +: 32] = bus.imem_instruction[i*32 +: 32];
            end
        end
    end

    assign deq     = (count != '0) && bus.out_ready;
    assign can_enq = (count < CNT_W'(QUEUE_DEPTH)) || deq;
    assign enq     = (state == ST_FETCH) && in_range && can_enq && !bus.redirect_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            fetch_pc    <= START_BYTE_ADDR;
            fetch_end_r <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (bus.redirect_valid) begin
            state       <= ST_FETCH;
            fetch_pc    <= bus.redirect_target & ~32'h3;
            fetch_end_r <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (!in_range) begin
                        state       <= ST_END;
                        fetch_end_r <= 1'b1;
                    end else if (can_enq) begin
                        fetch_pc <= fetch_pc + 32'(4 * FETCH_WIDTH);
                    end
                end
                default: state <= ST_END;
            endcase

            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every read is gated by a nonzero count.
    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem[tail]    <= fetch_pc;
            instr_mem[tail] <= bundle;
            mask_mem[tail]  <= slot_mask;
        end
    end

    assign bus.imem_address    = fetch_pc;
    assign bus.fetch_end       = fetch_end_r;
    assign bus.out_valid       = (count != '0);
    assign bus.out_pc          = bus.out_valid ? pc_mem[head]    : '0;
    assign bus.out_instruction = bus.out_valid ? instr_mem[head] : '0;
    assign bus.out_slot_valid  = bus.out_valid ? mask_mem[head]  : '0;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a full-size instance and a MEM_DEPTH=5 instance.
module tb_fetch_controller;

    logic clock;
    logic rst_a;
    logic rst_b;
    int   tests_run;
    int   tests_failed;

    fetch_controller_if #(.FETCH_WIDTH(2)) bus_a ();
    fetch_controller_if #(.FETCH_WIDTH(2)) bus_b ();

    fetch_controller #(
        .FETCH_WIDTH(2), .QUEUE_DEPTH(4), .MEM_DEPTH(1024), .START_BYTE_ADDR(32'h0000_3000)
    ) dut_a (
        .clock(clock), .reset(rst_a), .bus(bus_a.master)
    );

    fetch_controller #(
        .FETCH_WIDTH(2), .QUEUE_DEPTH(4), .MEM_DEPTH(5), .START_BYTE_ADDR(32'h0000_3000)
    ) dut_b (
        .clock(clock), .reset(rst_b), .bus(bus_b.master)
    );

    // Word k holds 0x100+k; beyond the depth it returns an obvious junk pattern.
    function automatic logic [63:0] mem_bundle(input logic [31:0] addr, input int unsigned depth);
        logic [63:0] res;
        logic [31:0] idx;
        logic [31:0] w;
        idx = (addr - 32'h3000) >> 2;
        res = '0;
        for (int i = 0; i < 2; i++) begin
            w = idx + 32'(i);
            res[i*32 +: 32] = (w < depth) ? (32'h100 + w) : (32'hBAD0_0000 | w);
        end
        return res;
    endfunction

    always_comb bus_a.imem_instruction = mem_bundle(bus_a.imem_address, 1024);
    always_comb bus_b.imem_instruction = mem_bundle(bus_b.imem_address, 5);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        tests_run             = 0;
        tests_failed          = 0;
        rst_a                 = 1'b0;
        rst_b                 = 1'b0;
        bus_a.out_ready       = 1'b1;
        bus_a.redirect_valid  = 1'b0;
        bus_a.redirect_target = '0;
        bus_b.out_ready       = 1'b1;
        bus_b.redirect_valid  = 1'b0;
        bus_b.redirect_target = '0;
        tick(2);

        // Reset values
        check("rst_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_pc", 64'(bus_a.out_pc), 64'd0);
        check("rst_instr", bus_a.out_instruction, 64'd0);
        check("rst_mask", 64'(bus_a.out_slot_valid), 64'd0);
        check("rst_end", 64'(bus_a.fetch_end), 64'd0);
        check("rst_addr", 64'(bus_a.imem_address), 64'h3000);

        // Free-running stream from reset
        rst_a = 1'b1;
        tick();
        check("t1_edge1_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("t1_edge2_valid", 64'(bus_a.out_valid), 64'd1);
        check("t1_pc0", 64'(bus_a.out_pc), 64'h3000);
        check("t1_instr0", bus_a.out_instruction, 64'h0000_0101_0000_0100);
        check("t1_mask0", 64'(bus_a.out_slot_valid), 64'b11);
        tick();
        check("t1_pc1", 64'(bus_a.out_pc), 64'h3008);
        check("t1_instr1", bus_a.out_instruction, 64'h0000_0103_0000_0102);
        tick();
        check("t1_pc2", 64'(bus_a.out_pc), 64'h3010);

        // Backpressure: fill, then a simultaneous pop and push
        rst_a = 1'b0;
        bus_a.out_ready = 1'b0;
        tick();
        rst_a = 1'b1;
        tick(5);
        check("t2_full_addr", 64'(bus_a.imem_address), 64'h3020);
        check("t2_full_head", 64'(bus_a.out_pc), 64'h3000);
        tick();
        check("t2_held_addr", 64'(bus_a.imem_address), 64'h3020);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check("t2_swap_head", 64'(bus_a.out_pc), 64'h3008);
        check("t2_swap_addr", 64'(bus_a.imem_address), 64'h3028);
        tick();
        check("t2_still_full", 64'(bus_a.imem_address), 64'h3028);
        bus_a.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t2_drain_pc", 64'(bus_a.out_pc), 64'(32'h3008 + 32'(8 * k)));
        end

        // Redirect with three queued bundles
        rst_a = 1'b0;
        bus_a.out_ready = 1'b0;
        tick();
        rst_a = 1'b1;
        tick(4);
        check("t3_addr_before", 64'(bus_a.imem_address), 64'h3018);
        bus_a.out_ready       = 1'b1;
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 32'h3043;
        tick();
        bus_a.redirect_valid = 1'b0;
        check("t3_flush_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("t3_tgt_valid", 64'(bus_a.out_valid), 64'd1);
        check("t3_tgt_pc", 64'(bus_a.out_pc), 64'h3040);
        check("t3_tgt_instr", bus_a.out_instruction, 64'h0000_0111_0000_0110);
        tick();
        check("t3_next_pc", 64'(bus_a.out_pc), 64'h3048);

        // Back-to-back redirects: last one wins
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 32'h3100;
        tick();
        bus_a.redirect_target = 32'h3200;
        tick();
        bus_a.redirect_valid = 1'b0;
        check("t3b_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("t3b_pc", 64'(bus_a.out_pc), 64'h3200);
        check("t3b_instr", bus_a.out_instruction, 64'h0000_0181_0000_0180);

        // Redirect below the memory base
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 32'h2FF0;
        tick();
        bus_a.redirect_valid = 1'b0;
        check("t5_end_early", 64'(bus_a.fetch_end), 64'd0);
        check("t5_addr", 64'(bus_a.imem_address), 64'h2FF0);
        tick();
        check("t5_end", 64'(bus_a.fetch_end), 64'd1);
        check("t5_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("t5_addr_held", 64'(bus_a.imem_address), 64'h2FF0);
        check("t5_valid_held", 64'(bus_a.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        rst_a = 1'b0;
        bus_a.out_ready = 1'b0;
        tick();
        rst_a = 1'b1;
        tick(4);
        check("t6_pre_valid", 64'(bus_a.out_valid), 64'd1);
        rst_a = 1'b0;
        #2;
        check("t6_async_valid", 64'(bus_a.out_valid), 64'd0);
        check("t6_async_pc", 64'(bus_a.out_pc), 64'd0);
        check("t6_async_addr", 64'(bus_a.imem_address), 64'h3000);
        rst_a = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        check("t6_edge1_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("t6_restart_pc", 64'(bus_a.out_pc), 64'h3000);

        // Small memory: partial bundle, END, drain, redirect out of END
        rst_b = 1'b1;
        tick();
        check("t4_edge1_valid", 64'(bus_b.out_valid), 64'd0);
        tick();
        check("t4_pc0", 64'(bus_b.out_pc), 64'h3000);
        tick();
        check("t4_pc1", 64'(bus_b.out_pc), 64'h3008);
        tick();
        check("t4_pc2", 64'(bus_b.out_pc), 64'h3010);
        check("t4_mask2", 64'(bus_b.out_slot_valid), 64'b01);
        check("t4_instr2", bus_b.out_instruction, 64'h0000_0000_0000_0104);
        check("t4_end_not_yet", 64'(bus_b.fetch_end), 64'd0);
        tick();
        check("t4_end", 64'(bus_b.fetch_end), 64'd1);
        check("t4_end_addr", 64'(bus_b.imem_address), 64'h3018);
        check("t4_drained", 64'(bus_b.out_valid), 64'd0);
        check("t4_drained_pc", 64'(bus_b.out_pc), 64'd0);
        tick();
        check("t4_end_stays", 64'(bus_b.fetch_end), 64'd1);
        bus_b.redirect_valid  = 1'b1;
        bus_b.redirect_target = 32'h3000;
        tick();
        bus_b.redirect_valid = 1'b0;
        check("t4_end_cleared", 64'(bus_b.fetch_end), 64'd0);
        check("t4_redir_valid", 64'(bus_b.out_valid), 64'd0);
        tick();
        check("t4_refetch_pc", 64'(bus_b.out_pc), 64'h3000);
        check("t4_refetch_mask", 64'(bus_b.out_slot_valid), 64'b11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
